// File: rtl/countdown_pkg.sv
// Shared state type for the countdown timer.
package countdown_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

endpackage

// File: rtl/countdown_timer_tick_prescaler.sv
// Divides clk by PRESCALE; tick marks the last phase of each period.
module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] phase;

  // tick reflects the held phase, so the owner can see it even while paused
  assign tick = (phase == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase <= '0;
    end else if (clear) begin
      phase <= '0;
    end else if (enable) begin
      phase <= tick ? '0 : phase + 1'b1;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with start/pause and one-cycle done pulse at zero.
// Define COUNTDOWN_AUTO_RELOAD_EN to restart from the loaded value at terminal.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  state_t           state, state_next;
  logic [WIDTH-1:0] count_next;
  logic             done_next;
  logic             tick;
  logic             terminal;
  logic             prescale_en;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload;
`endif

  // Terminal decision uses the pre-pause state, so it beats a same-cycle pause
  assign terminal    = (state == RUN) && tick && (count == WIDTH'(1));
  assign prescale_en = !load && (state == RUN) && (!pause || terminal);

  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (prescale_en),
    .clear  (load),
    .tick   (tick)
  );

  always_comb begin
    state_next = state;
    count_next = count;
    done_next  = 1'b0;
    if (load) begin
      count_next = load_value;
      state_next = IDLE;
    end else begin
      case (state)
        RUN: begin
          if (terminal) begin
            done_next = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            if (reload != '0) begin
              count_next = reload;
            end else begin
              count_next = '0;
              state_next = IDLE;
            end
`else
            count_next = '0;
            state_next = IDLE;
`endif
          end else if (pause) begin
            state_next = PAUSE;
          end else if (tick) begin
            count_next = count - 1'b1;
          end
        end
        PAUSE: begin
          if (!pause && start) state_next = RUN;
        end
        IDLE: begin
          if (!pause && start && (count != '0)) state_next = RUN;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      busy  <= (state_next != IDLE);
      done  <= done_next;
    end
  end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    reload <= '0;
    else if (load) reload <= load_value;
  end
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: PRESCALE=1 and PRESCALE=4 instances share stimulus.
module tb_countdown_timer;

  localparam int W = 4;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         load = 1'b0;
  logic         start = 1'b0;
  logic         pause = 1'b0;
  logic [W-1:0] load_value = '0;
  logic [W-1:0] count_a, count_b;
  logic         busy_a, busy_b, done_a, done_b;

  int tests = 0;
  int fails = 0;

  // st: 0 idle, 1 running, 2 paused; ph counts clocks since the last decrement
  typedef struct {
    int cnt;
    int rel;
    int ph;
    int st;
    bit done;
  } model_t;

  model_t ma, mb;

  always #5 clk = ~clk;

  countdown_timer #(.WIDTH(W), .PRESCALE(1)) dut_a (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .count(count_a), .busy(busy_a), .done(done_a)
  );

  countdown_timer #(.WIDTH(W), .PRESCALE(4)) dut_b (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .count(count_b), .busy(busy_b), .done(done_b)
  );

  function automatic model_t model_reset();
    model_t m;
    m.cnt = 0; m.rel = 0; m.ph = 0; m.st = 0; m.done = 1'b0;
    return m;
  endfunction

  function automatic model_t model_next(model_t m, int p, bit ld, int lv, bit s, bit pz);
    model_t n = m;
    n.done = 1'b0;
    if (ld) begin
      n.cnt = lv; n.rel = lv; n.ph = 0; n.st = 0;
    end else if (m.st == 1) begin
      if (m.ph == p - 1 && m.cnt == 1) begin
        n.done = 1'b1;
        n.ph = 0;
        if (AUTO && m.rel != 0) n.cnt = m.rel;
        else begin n.cnt = 0; n.st = 0; end
      end else if (pz) begin
        n.st = 2;
      end else if (m.ph == p - 1) begin
        n.ph = 0;
        n.cnt = m.cnt - 1;
      end else begin
        n.ph = m.ph + 1;
      end
    end else if (m.st == 2) begin
      if (!pz && s) n.st = 1;
    end else if (!pz && s && m.cnt != 0) begin
      n.st = 1;
    end
    return n;
  endfunction

  task automatic apply_stimulus(input bit ld, input int lv, input bit s, input bit pz);
    load = ld;
    load_value = W'(lv);
    start = s;
    pause = pz;
  endtask

  task automatic clock_step();
    @(posedge clk);
    ma = model_next(ma, 1, load, int'(load_value), start, pause);
    mb = model_next(mb, 4, load, int'(load_value), start, pause);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    tests++;
    if ({count_a, busy_a, done_a} !== {W'(0), 1'b0, 1'b0}) begin
      fails++;
      $display("[TB] FAIL reset_a: got count=%0d busy=%b done=%b, want 0 0 0", count_a, busy_a, done_a);
    end
    tests++;
    if ({count_b, busy_b, done_b} !== {W'(0), 1'b0, 1'b0}) begin
      fails++;
      $display("[TB] FAIL reset_b: got count=%0d busy=%b done=%b, want 0 0 0", count_b, busy_b, done_b);
    end
    ma = model_reset();
    mb = model_reset();
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_oneshot();
    int exp_cnt[4];
    exp_cnt = '{3, 2, 1, (AUTO ? 3 : 0)};
    apply_stimulus(1, 3, 0, 0); clock_step();
    apply_stimulus(0, 0, 1, 0); clock_step();
    apply_stimulus(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (count_a !== W'(exp_cnt[i]) || done_a !== (i == 3) || busy_a !== (i != 3 || AUTO)) begin
        fails++;
        $display("[TB] FAIL oneshot step %0d: got count=%0d busy=%b done=%b, want count=%0d busy=%b done=%b",
                 i, count_a, busy_a, done_a, exp_cnt[i], (i != 3 || AUTO), (i == 3));
      end
      tests++;
      if ({count_b, busy_b, done_b} !== {W'(mb.cnt), mb.st != 0, mb.done}) begin
        fails++;
        $display("[TB] FAIL oneshot_b step %0d: got count=%0d busy=%b done=%b, want count=%0d busy=%b done=%b",
                 i, count_b, busy_b, done_b, mb.cnt, mb.st != 0, mb.done);
      end
      clock_step();
    end
    apply_stimulus(1, 0, 0, 0); clock_step();
    apply_stimulus(0, 0, 0, 0);
  endtask

  task automatic test_pause_resume();
    int n;
    apply_stimulus(1, 10, 0, 0); clock_step();
    apply_stimulus(0, 0, 1, 0); clock_step();
    apply_stimulus(0, 0, 0, 0);
    for (n = 0; n < 40 && count_b !== W'(8); n++) clock_step();
    tests++;
    if (count_b !== W'(8)) begin
      fails++;
      $display("[TB] FAIL pause_reach8: got count=%0d, want 8 within 40 cycles", count_b);
    end
    apply_stimulus(0, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      clock_step();
      tests++;
      if ({count_b, busy_b, done_b} !== {W'(8), 1'b1, 1'b0}) begin
        fails++;
        $display("[TB] FAIL pause_hold cycle %0d: got count=%0d busy=%b done=%b, want 8 1 0", i, count_b, busy_b, done_b);
      end
    end
    apply_stimulus(0, 0, 1, 0); clock_step();
    apply_stimulus(0, 0, 0, 0);
    for (n = 0; n < 100 && done_b !== 1'b1; n++) clock_step();
    tests++;
    if (n != 32 || count_b !== W'(AUTO ? 10 : 0)) begin
      fails++;
      $display("[TB] FAIL pause_resume_latency: got %0d cycles count=%0d, want 32 cycles count=%0d",
               n, count_b, (AUTO ? 10 : 0));
    end
    apply_stimulus(1, 0, 0, 0); clock_step();
    apply_stimulus(0, 0, 0, 0);
  endtask

  task automatic test_load_interrupt();
    int dones = 0;
    apply_stimulus(1, 5, 0, 0); clock_step();
    apply_stimulus(0, 0, 1, 0); clock_step();
    apply_stimulus(0, 0, 0, 0); clock_step();
    tests++;
    if (count_a !== W'(4)) begin
      fails++;
      $display("[TB] FAIL interrupt_pre: got count=%0d, want 4", count_a);
    end
    apply_stimulus(1, 7, 0, 0); clock_step();
    apply_stimulus(0, 0, 0, 0);
    tests++;
    if ({count_a, busy_a, done_a} !== {W'(7), 1'b0, 1'b0}) begin
      fails++;
      $display("[TB] FAIL interrupt_load: got count=%0d busy=%b done=%b, want 7 0 0", count_a, busy_a, done_a);
    end
    apply_stimulus(0, 0, 1, 0); clock_step();
    apply_stimulus(0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      clock_step();
      if (done_a === 1'b1) dones++;
    end
    tests++;
    if (dones != 1 || count_a !== W'(AUTO ? 7 : 0)) begin
      fails++;
      $display("[TB] FAIL interrupt_restart: got dones=%0d count=%0d, want 1 and %0d", dones, count_a, (AUTO ? 7 : 0));
    end
    apply_stimulus(1, 0, 0, 0); clock_step();
    apply_stimulus(0, 0, 0, 0);
  endtask

  task automatic test_zero_and_full();
    int dones = 0;
    int busies = 0;
    apply_stimulus(1, 0, 0, 0); clock_step();
    apply_stimulus(0, 0, 1, 0); clock_step();
    apply_stimulus(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      if (done_a === 1'b1 || done_b === 1'b1) dones++;
      if (busy_a !== 1'b0 || busy_b !== 1'b0) busies++;
      clock_step();
    end
    tests++;
    if (dones != 0 || busies != 0 || count_a !== W'(0)) begin
      fails++;
      $display("[TB] FAIL zero_start: got dones=%0d busy_cycles=%0d count=%0d, want 0 0 0", dones, busies, count_a);
    end
    dones = 0;
    apply_stimulus(1, 15, 0, 0); clock_step();
    apply_stimulus(0, 0, 1, 0); clock_step();
    apply_stimulus(0, 0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      clock_step();
      if (done_a === 1'b1) dones++;
    end
    tests++;
    if (dones != 1 || count_a !== W'(AUTO ? 15 : 0)) begin
      fails++;
      $display("[TB] FAIL full_scale: got dones=%0d count=%0d, want 1 and %0d", dones, count_a, (AUTO ? 15 : 0));
    end
    clock_step();
    tests++;
    if (count_a !== W'(AUTO ? 14 : 0) || done_a !== 1'b0) begin
      fails++;
      $display("[TB] FAIL full_no_wrap: got count=%0d done=%b, want %0d 0", count_a, done_a, (AUTO ? 14 : 0));
    end
    apply_stimulus(1, 0, 0, 0); clock_step();
    apply_stimulus(0, 0, 0, 0);
  endtask

  task automatic test_async_reset();
    int n;
    int bad = 0;
    apply_stimulus(1, 5, 0, 0); clock_step();
    apply_stimulus(0, 0, 1, 0); clock_step();
    apply_stimulus(0, 0, 0, 0);
    for (n = 0; n < 10 && count_a !== W'(3); n++) clock_step();
    #2 reset = 1'b0;
    #1;
    tests++;
    if ({count_a, busy_a, done_a, count_b, busy_b, done_b} !== {W'(0), 1'b0, 1'b0, W'(0), 1'b0, 1'b0}) begin
      fails++;
      $display("[TB] FAIL async_reset: got a=%0d/%b/%b b=%0d/%b/%b, want all zero",
               count_a, busy_a, done_a, count_b, busy_b, done_b);
    end
    ma = model_reset();
    mb = model_reset();
    #1 reset = 1'b1;
    apply_stimulus(0, 0, 1, 0); clock_step();
    apply_stimulus(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      if (count_a !== W'(0) || busy_a !== 1'b0 || done_a !== 1'b0) bad++;
      clock_step();
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("[TB] FAIL post_reset_start: got %0d non-idle cycles, want 0", bad);
    end
  endtask

  task automatic test_auto_reload();
    int dones = 0;
    int moved = 0;
    apply_stimulus(1, 2, 0, 0); clock_step();
    apply_stimulus(0, 0, 1, 0); clock_step();
    apply_stimulus(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      clock_step();
      if (done_a === 1'b1) dones++;
    end
    tests++;
    if (dones != (AUTO ? 3 : 1) || count_a !== W'(AUTO ? 2 : 0) || busy_a !== AUTO) begin
      fails++;
      $display("[TB] FAIL auto_reload: got dones=%0d count=%0d busy=%b, want %0d %0d %b",
               dones, count_a, busy_a, (AUTO ? 3 : 1), (AUTO ? 2 : 0), AUTO);
    end
    apply_stimulus(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      clock_step();
      if (count_a !== W'(AUTO ? 2 : 0) || done_a !== 1'b0) moved++;
    end
    tests++;
    if (moved != 0) begin
      fails++;
      $display("[TB] FAIL auto_reload_pause: got %0d changed cycles, want 0", moved);
    end
    apply_stimulus(1, 0, 0, 0); clock_step();
    apply_stimulus(0, 0, 0, 0);
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 600; i++) begin
      apply_stimulus(($urandom_range(0, 15) == 0), $urandom_range(0, 15),
                     ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
      clock_step();
      tests++;
      if ({count_a, busy_a, done_a} !== {W'(ma.cnt), ma.st != 0, ma.done}) begin
        fails++;
        if (errs++ < 10)
          $display("[TB] FAIL random_a cycle %0d: got count=%0d busy=%b done=%b, want count=%0d busy=%b done=%b",
                   i, count_a, busy_a, done_a, ma.cnt, ma.st != 0, ma.done);
      end
      tests++;
      if ({count_b, busy_b, done_b} !== {W'(mb.cnt), mb.st != 0, mb.done}) begin
        fails++;
        if (errs++ < 10)
          $display("[TB] FAIL random_b cycle %0d: got count=%0d busy=%b done=%b, want count=%0d busy=%b done=%b",
                   i, count_b, busy_b, done_b, mb.cnt, mb.st != 0, mb.done);
      end
    end
    apply_stimulus(0, 0, 0, 0);
  endtask

  initial begin
    ma = model_reset();
    mb = model_reset();
    test_reset();
    test_oneshot();
    test_pause_resume();
    test_load_interrupt();
    test_zero_and_full();
    test_async_reset();
    test_auto_reload();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable down-counter that consumes the up-count convention of our counter blocks.
- Software or an FSM loads a terminal count, starts it, and can pause and resume it. The block decrements once per prescaled tick and raises a one-cycle done pulse on reaching zero.
- Sits beside the free-running counters as the timeout/delay source for control logic.

Parameters:
- WIDTH, 4, bit width of count and load_value.
- PRESCALE, 1, clk cycles per decrement; legal range >= 1.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- load  input  1  synchronous load strobe.
- load_value  input  WIDTH  value captured on load.
- start  input  1  begin or resume counting.
- pause  input  1  freeze counting.
- count  output  WIDTH  current remaining count.
- busy  output  1  high in RUN or PAUSE.
- done  output  1  one-cycle pulse at terminal count.

Behaviour:
- Interface decided: reset reset, asynchronous, active-low; clock clk.
- Reset (reset=0, takes effect immediately, independent of clk):
  - count=0, reload register=0, prescaler=0, state=IDLE, busy=0, done=0.
  - Reset mid-RUN aborts with no done pulse.
- States: IDLE, RUN, PAUSE. busy is registered and equals (state!=IDLE).
- Input priority each edge: load > pause > start.
- load, any state:
  - count and reload register <= load_value.
  - prescaler <= 0, state <= IDLE, done <= 0.
- start in IDLE:
  - count!=0: state <= RUN.
  - count==0: ignored, no done.
- start in RUN: no effect.
- pause in RUN: state <= PAUSE; count and prescaler hold.
- start in PAUSE (pause low): state <= RUN; prescaler resumes from its held value.
- RUN tick rule:
  - prescaler increments each cycle; at PRESCALE-1 it wraps to 0 and a decrement occurs that cycle.
  - PRESCALE=1: decrement every cycle.
- Decrement with count>1: count <= count-1.
- Decrement with count==1 (terminal):
  - count <= 0, done <= 1 for exactly one cycle, state <= IDLE, busy <= 0, all on the same edge.
- Latency: start sampled at edge k with load N gives count==0 and done==1 after edge k+N*PRESCALE.
- done is 0 every other cycle. A pause asserted in the terminal cycle loses to the decrement, because the terminal decision uses the pre-pause state.
- Arithmetic: unsigned WIDTH-bit; count never wraps below 0. load_value = 2^WIDTH-1 is legal.

Optional Feature:
- Macro: COUNTDOWN_AUTO_RELOAD_EN.
- Defined: at terminal, count <= reload register instead of 0, done pulses, state stays RUN, busy stays 1. Gives a periodic done every reload*PRESCALE cycles until pause or load. If the reload register is 0, the block behaves as not defined.
- Not defined: one-shot behaviour as above.

Decomposition:
- Package countdown_pkg: state enum typedef (IDLE, RUN, PAUSE) and state width constant.
- One natural sub-module, tick_prescaler:
  - Parameterised by PRESCALE.
  - Inputs: enable, clear. Output: tick.
  - Holds its count when enable is low.
  - Instantiated once in countdown_timer.

Test Plan:
- PRESCALE=1, load 3, start 1 cycle -> count 3,2,1,0 on successive edges; done high only on the cycle count becomes 0; busy falls on that same edge.
- PRESCALE=4, load 10, start, pause when count==8, hold pause 20 cycles -> count stays 8, busy=1, done=0; drop pause, pulse start -> reaches 0 exactly 32 cycles later with prescaler phase preserved.
- Load 5, start, at count==4 pulse load with 7 -> count=7, state IDLE, busy=0, no done; start again -> counts 7..0 with one done.
- Load 0, pulse start -> count stays 0, busy=0, done never asserts. Load 15 (WIDTH=4) -> full 15 decrements, done once, no wrap to 15.
- Load 5, start, drive reset=0 between clk edges at count==3 -> count=0, busy=0, done=0 immediately; after release, start with count 0 is ignored.
- With COUNTDOWN_AUTO_RELOAD_EN, PRESCALE=1, load 2, start -> count 2,1,2,1...; done every 2nd cycle; busy stays 1; pause freezes; without the macro count ends at 0 with a single done.
